// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with a valid/ready handshake and a two-entry skid buffer.
// in_ready is registered, so a MEM-side stall never forms a combinational path back into EX.
module ex_mem_pipe_stage #(
    parameter int XLEN       = 32,
    parameter int RA_W       = 5,
    parameter int MODE_W     = 3,
    parameter bit ZERO_RD_WB = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              regWrite_E,
    input  logic              memWrite_E,
    input  logic              memRead_E,
    input  logic              resultScr_E,
    input  logic [XLEN-1:0]   alu_rsl_E,
    input  logic [XLEN-1:0]   write_Data_E,
    input  logic [RA_W-1:0]   rd_E,
    input  logic [MODE_W-1:0] mode_E,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              regWrite_M,
    output logic              memWrite_M,
    output logic              memRead_M,
    output logic              resultScr_M,
    output logic [XLEN-1:0]   alu_rsl_M,
    output logic [XLEN-1:0]   write_Data_M,
    output logic [RA_W-1:0]   rd_M,
    output logic [MODE_W-1:0] mode_M
);

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              mem_read;
        logic              result_src;
        logic [XLEN-1:0]   alu_rsl;
        logic [XLEN-1:0]   write_data;
        logic [RA_W-1:0]   rd;
        logic [MODE_W-1:0] mode;
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t  state_q, state_d;
    bundle_t main_q, skid_q, in_bundle;
    logic    in_ready_q;
    logic    in_fire, out_fire;
    logic    load_main_in, load_main_skid, load_skid;

    // Writes to x0 are squashed at capture so MEM/WB never see a bogus regWrite.
    always_comb begin
        in_bundle            = '0;
        in_bundle.reg_write  = regWrite_E & ((ZERO_RD_WB == 1'b0) | (rd_E != '0));
        in_bundle.mem_write  = memWrite_E;
        in_bundle.mem_read   = memRead_E;
        in_bundle.result_src = resultScr_E;
        in_bundle.alu_rsl    = alu_rsl_E;
        in_bundle.write_data = write_Data_E;
        in_bundle.rd         = rd_E;
        in_bundle.mode       = mode_E;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready_q & ~flush;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d      = BUSY;
                    load_main_in = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && !out_fire) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // Skid always drains into main before any new entry, keeping FIFO order.
                if (out_fire) begin
                    state_d        = BUSY;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d        = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)
                main_q <= in_bundle;
            else if (load_main_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= in_bundle;
        end
    end

    // Control is qualified by out_valid; data simply holds the last captured value.
    assign regWrite_M   = main_q.reg_write  & out_valid;
    assign memWrite_M   = main_q.mem_write  & out_valid;
    assign memRead_M    = main_q.mem_read   & out_valid;
    assign resultScr_M  = main_q.result_src & out_valid;
    assign alu_rsl_M    = main_q.alu_rsl;
    assign write_Data_M = main_q.write_data;
    assign rd_M         = main_q.rd;
    assign mode_M       = main_q.mode;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: directed scenarios then random traffic, checked against a
// queue model of a two-deep FIFO with a registered ready.
module tb_ex_mem_pipe_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic        regWrite_E, memWrite_E, memRead_E, resultScr_E;
    logic [31:0] alu_rsl_E, write_Data_E;
    logic [4:0]  rd_E;
    logic [2:0]  mode_E;
    logic        regWrite_M, memWrite_M, memRead_M, resultScr_M;
    logic [31:0] alu_rsl_M, write_Data_M;
    logic [4:0]  rd_M;
    logic [2:0]  mode_M;

    always #5 clk = ~clk;

    ex_mem_pipe_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .regWrite_E(regWrite_E), .memWrite_E(memWrite_E), .memRead_E(memRead_E),
        .resultScr_E(resultScr_E), .alu_rsl_E(alu_rsl_E), .write_Data_E(write_Data_E),
        .rd_E(rd_E), .mode_E(mode_E),
        .out_valid(out_valid), .out_ready(out_ready),
        .regWrite_M(regWrite_M), .memWrite_M(memWrite_M), .memRead_M(memRead_M),
        .resultScr_M(resultScr_M), .alu_rsl_M(alu_rsl_M), .write_Data_M(write_Data_M),
        .rd_M(rd_M), .mode_M(mode_M)
    );

    typedef struct {
        logic        rw, mw, mr, rs;
        logic [31:0] alu, wd;
        logic [4:0]  rd;
        logic [2:0]  mode;
    } bnd_t;

    bnd_t q[$];
    bit   rdy_exp;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference: a 2-deep FIFO; ready seen by EX is the
    // "fewer than two held" condition as it stood after the previous edge.
    task automatic model_edge();
        bit   ia, oa;
        bnd_t b;
        ia = in_valid && rdy_exp && !flush;
        oa = (q.size() > 0) && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (oa) void'(q.pop_front());
            if (ia) begin
                b.rw = regWrite_E && (rd_E != 5'd0);
                b.mw = memWrite_E; b.mr = memRead_E; b.rs = resultScr_E;
                b.alu = alu_rsl_E; b.wd = write_Data_E; b.rd = rd_E; b.mode = mode_E;
                q.push_back(b);
            end
        end
        rdy_exp = (q.size() < 2);
    endtask

    task automatic check_all();
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, rdy_exp);
        if (q.size() > 0) begin
            chk("regWrite_M", regWrite_M, q[0].rw);
            chk("memWrite_M", memWrite_M, q[0].mw);
            chk("memRead_M", memRead_M, q[0].mr);
            chk("resultScr_M", resultScr_M, q[0].rs);
            chk("alu_rsl_M", alu_rsl_M, q[0].alu);
            chk("write_Data_M", write_Data_M, q[0].wd);
            chk("rd_M", rd_M, q[0].rd);
            chk("mode_M", mode_M, q[0].mode);
        end else begin
            chk("ctrl_idle", {regWrite_M, memWrite_M, memRead_M, resultScr_M}, 4'b0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic send(input logic v, input logic [31:0] alu, input logic rw, input logic [4:0] rd,
                        input logic mw, input logic mr, input logic rs,
                        input logic [31:0] wd, input logic [2:0] mode);
        in_valid = v; alu_rsl_E = alu; regWrite_E = rw; rd_E = rd;
        memWrite_E = mw; memRead_E = mr; resultScr_E = rs; write_Data_E = wd; mode_E = mode;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        send(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0);
        rdy_exp = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_alu", alu_rsl_M, 32'h0);
        chk("rst_regWrite", regWrite_M, 1'b0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        cycle();
        chk("post_rst_ready", in_ready, 1'b1);

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 32'(16 * (i + 1)), 1'b1, 5'(i + 1), 1'b0, 1'b0, 1'b0, 32'h0, 3'd2);
            cycle();
            chk("stream_alu", alu_rsl_M, 32'(16 * (i + 1)));
            chk("stream_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        cycle();

        // Stall into FULL, then drain in order.
        out_ready = 1'b0;
        send(1'b1, 32'hA, 1'b1, 5'd1, 1'b0, 1'b1, 1'b1, 32'h0, 3'd0);
        cycle();
        send(1'b1, 32'hB, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1, 32'h0, 3'd0);
        cycle();
        chk("full_ready", in_ready, 1'b0);
        send(1'b1, 32'hC, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 32'h0, 3'd0);
        cycle();
        chk("full_hold_a", alu_rsl_M, 32'hA);
        out_ready = 1'b1;
        cycle();
        chk("drain_b", alu_rsl_M, 32'hB);
        cycle();
        chk("drain_c", alu_rsl_M, 32'hC);
        in_valid = 1'b0;
        cycle();
        chk("drain_empty", out_valid, 1'b0);

        // Flush while FULL with a new input pending.
        out_ready = 1'b0;
        send(1'b1, 32'h1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0);
        cycle();
        send(1'b1, 32'h2, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0);
        cycle();
        send(1'b1, 32'hD, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0);
        flush = 1'b1;
        cycle();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_rw", regWrite_M, 1'b0);
        flush = 1'b0; in_valid = 1'b0;
        cycle();
        chk("flush_dropped", out_valid, 1'b0);

        // x0 writeback suppression.
        out_ready = 1'b1;
        send(1'b1, 32'h55, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0);
        cycle();
        chk("rd0_rw", regWrite_M, 1'b0);
        chk("rd0_alu", alu_rsl_M, 32'h55);
        send(1'b1, 32'h66, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0);
        cycle();
        chk("rd5_rw", regWrite_M, 1'b1);

        // Store bundle.
        send(1'b1, 32'h100, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 3'b010);
        cycle();
        chk("st_mw", memWrite_M, 1'b1);
        chk("st_wd", write_Data_M, 32'hDEADBEEF);
        chk("st_mode", mode_M, 3'b010);

        // Asynchronous reset while holding a valid bundle.
        out_ready = 1'b0;
        send(1'b1, 32'h77, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1, 32'h0, 3'd1);
        cycle();
        chk("pre_arst_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_rw", regWrite_M, 1'b0);
        chk("arst_alu", alu_rsl_M, 32'h0);
        chk("arst_ready", in_ready, 1'b0);
        q.delete();
        rdy_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("rel_ready", in_ready, 1'b1);
        chk("rel_valid", out_valid, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            send(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 3'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
